// File: rtl/fake_n64_bus_sequencer_if.sv
// Joybus sequencer bus: receive-side command in, transmitter control out.
// master = sequencer side, slave = rx/tx datapath side.
interface fake_n64_bus_sequencer_if;
   logic       rx_cmd_valid;
   logic [7:0] rx_cmd;
   logic       tx_handoff;
   logic       cur_operation;
   logic [7:0] cmd;
   logic [1:0] seq_state;
   logic [7:0] resp_count;
   logic       err_unsupported;
   logic       err_overrun;
   logic       err_timeout;

   modport master (
      input  rx_cmd_valid, rx_cmd, tx_handoff,
      output cur_operation, cmd, seq_state, resp_count,
      output err_unsupported, err_overrun, err_timeout
   );

   modport slave (
      output rx_cmd_valid, rx_cmd, tx_handoff,
      input  cur_operation, cmd, seq_state, resp_count,
      input  err_unsupported, err_overrun, err_timeout
   );
endinterface

// File: rtl/fake_n64_bus_sequencer.sv
// Joybus line-direction sequencer: IDLE -> TURNAROUND -> TX -> GUARD.
// Optional TX abort timeout enabled by FAKE_N64_SEQ_TIMEOUT_EN.
module fake_n64_bus_sequencer #(
   parameter int TURNAROUND_CYCLES = 16,
   parameter int GUARD_CYCLES      = 8,
   parameter int TIMEOUT_CYCLES    = 1024
) (
   input logic sample_clk,
   input logic reset_n,
   fake_n64_bus_sequencer_if.master bus
);

   if (TURNAROUND_CYCLES < 1 || TURNAROUND_CYCLES > 255 ||
       GUARD_CYCLES < 1 || GUARD_CYCLES > 255 ||
       TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
      $error("fake_n64_bus_sequencer: parameter out of range");
   end

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      TURNAROUND = 2'd1,
      TX         = 2'd2,
      GUARD      = 2'd3
   } state_t;

   localparam logic [15:0] TA_LAST = 16'(TURNAROUND_CYCLES - 1);
   localparam logic [15:0] GD_LAST = 16'(GUARD_CYCLES - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        cur_op_q, cur_op_d;
   logic [7:0]  cmd_q, cmd_d;
   logic [7:0]  resp_q, resp_d;
   logic        err_unsup_q, err_unsup_d;
   logic        err_ovr_q, err_ovr_d;
   logic        handoff_q;
   logic        handoff_edge;
   logic        cmd_ok;

   assign handoff_edge = bus.tx_handoff != handoff_q;
   assign cmd_ok = (bus.rx_cmd == 8'h00) || (bus.rx_cmd == 8'h01) ||
                   (bus.rx_cmd == 8'hFF);

`ifdef FAKE_N64_SEQ_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic err_to_q, err_to_d;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 16'd1;
      cur_op_d    = cur_op_q;
      cmd_d       = cmd_q;
      resp_d      = resp_q;
      err_unsup_d = 1'b0;
      err_ovr_d   = 1'b0;
`ifdef FAKE_N64_SEQ_TIMEOUT_EN
      err_to_d    = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.rx_cmd_valid) begin
               if (cmd_ok) begin
                  cmd_d   = bus.rx_cmd;
                  state_d = TURNAROUND;
               end else begin
                  err_unsup_d = 1'b1;
               end
            end
         end
         TURNAROUND: begin
            if (cnt_q == TA_LAST) begin
               state_d  = TX;
               cur_op_d = 1'b1;
            end
         end
         TX: begin
            // a handoff edge beats a simultaneous timeout
            if (handoff_edge) begin
               state_d  = GUARD;
               cur_op_d = 1'b0;
               resp_d   = resp_q + 8'd1;
            end
`ifdef FAKE_N64_SEQ_TIMEOUT_EN
            else if (cnt_q == TO_LAST) begin
               state_d  = GUARD;
               cur_op_d = 1'b0;
               err_to_d = 1'b1;
            end
`endif
         end
         GUARD: begin
            if (cnt_q == GD_LAST) begin
               state_d = IDLE;
            end
         end
      endcase
      if (bus.rx_cmd_valid && state_q != IDLE) begin
         err_ovr_d = 1'b1;
      end
      if (state_d != state_q) begin
         cnt_d = 16'd0;
      end
   end

   always_ff @(posedge sample_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= 16'd0;
         cur_op_q    <= 1'b0;
         cmd_q       <= 8'h00;
         resp_q      <= 8'd0;
         err_unsup_q <= 1'b0;
         err_ovr_q   <= 1'b0;
         handoff_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cur_op_q    <= cur_op_d;
         cmd_q       <= cmd_d;
         resp_q      <= resp_d;
         err_unsup_q <= err_unsup_d;
         err_ovr_q   <= err_ovr_d;
         handoff_q   <= bus.tx_handoff;
      end
   end

`ifdef FAKE_N64_SEQ_TIMEOUT_EN
   always_ff @(posedge sample_clk or negedge reset_n) begin
      if (!reset_n) begin
         err_to_q <= 1'b0;
      end else begin
         err_to_q <= err_to_d;
      end
   end
   assign bus.err_timeout = err_to_q;
`else
   assign bus.err_timeout = 1'b0;
`endif

   assign bus.cur_operation   = cur_op_q;
   assign bus.cmd             = cmd_q;
   assign bus.seq_state       = state_q;
   assign bus.resp_count      = resp_q;
   assign bus.err_unsupported = err_unsup_q;
   assign bus.err_overrun     = err_ovr_q;

endmodule

// File: tb/tb_fake_n64_bus_sequencer.sv
// Bench for fake_n64_bus_sequencer: timestamp-based reference model,
// per-cycle compare, directed literal checks and random traffic.
module tb_fake_n64_bus_sequencer;

   localparam int TA = 16;
   localparam int GD = 8;
   localparam int TO = 64;

   logic sample_clk = 1'b0;
   logic reset_n = 1'b0;
   logic chk_en = 1'b0;
   int total = 0;
   int bad = 0;

   fake_n64_bus_sequencer_if bus ();

   fake_n64_bus_sequencer #(
      .TURNAROUND_CYCLES(TA),
      .GUARD_CYCLES(GD),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .sample_clk(sample_clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   always #5 sample_clk = ~sample_clk;

   // reference model: phase plus absolute cycle deadlines
   int         m_cyc = 0;
   int         m_ph = 0;
   int         m_tx_at = 0;
   int         m_tx_entry = 0;
   int         m_idle_at = 0;
   logic       m_prev = 1'b0;
   logic [7:0] m_cmd = 8'h00;
   logic [7:0] m_resp = 8'd0;
   logic       m_eu = 1'b0;
   logic       m_eo = 1'b0;
   logic       m_et = 1'b0;

   initial forever begin
      logic ed;
      @(posedge sample_clk or negedge reset_n);
      if (!reset_n) begin
         m_ph = 0; m_prev = 1'b0; m_cmd = 8'h00; m_resp = 8'd0;
         m_eu = 1'b0; m_eo = 1'b0; m_et = 1'b0;
      end else begin
         ed = bus.tx_handoff != m_prev;
         m_prev = bus.tx_handoff;
         m_eu = 1'b0; m_eo = 1'b0; m_et = 1'b0;
         if (bus.rx_cmd_valid && m_ph != 0) m_eo = 1'b1;
         case (m_ph)
            0: if (bus.rx_cmd_valid) begin
               if (bus.rx_cmd inside {8'h00, 8'h01, 8'hFF}) begin
                  m_cmd = bus.rx_cmd;
                  m_ph = 1;
                  m_tx_at = m_cyc + TA;
               end else begin
                  m_eu = 1'b1;
               end
            end
            1: if (m_cyc == m_tx_at) begin
               m_ph = 2;
               m_tx_entry = m_cyc;
            end
            2: if (ed) begin
               m_resp = m_resp + 8'd1;
               m_ph = 3;
               m_idle_at = m_cyc + GD;
            end
`ifdef FAKE_N64_SEQ_TIMEOUT_EN
            else if (m_cyc == m_tx_entry + TO) begin
               m_et = 1'b1;
               m_ph = 3;
               m_idle_at = m_cyc + GD;
            end
`endif
            default: if (m_cyc == m_idle_at) m_ph = 0;
         endcase
         m_cyc++;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   initial forever begin
      @(negedge sample_clk);
      if (chk_en && reset_n) begin
         chk("m.seq", 32'(bus.seq_state), 32'(m_ph));
         chk("m.cur", 32'(bus.cur_operation), 32'(m_ph == 2));
         chk("m.cmd", 32'(bus.cmd), 32'(m_cmd));
         chk("m.resp", 32'(bus.resp_count), 32'(m_resp));
         chk("m.eu", 32'(bus.err_unsupported), 32'(m_eu));
         chk("m.eo", 32'(bus.err_overrun), 32'(m_eo));
         chk("m.et", 32'(bus.err_timeout), 32'(m_et));
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge sample_clk);
   endtask

   task automatic pulse_cmd(input logic [7:0] c);
      bus.rx_cmd = c;
      bus.rx_cmd_valid = 1'b1;
      @(negedge sample_clk);
      bus.rx_cmd_valid = 1'b0;
   endtask

   task automatic toggle();
      bus.tx_handoff = ~bus.tx_handoff;
      @(negedge sample_clk);
   endtask

   initial begin
      int n;
      bus.rx_cmd_valid = 1'b0;
      bus.rx_cmd = 8'h00;
      bus.tx_handoff = 1'b0;
      cycles(3);
      reset_n = 1'b1;
      chk_en = 1'b1;
      cycles(1);
      chk("rst.cur", 32'(bus.cur_operation), 0);
      chk("rst.cmd", 32'(bus.cmd), 0);
      chk("rst.resp", 32'(bus.resp_count), 0);
      chk("rst.seq", 32'(bus.seq_state), 0);

      pulse_cmd(8'h01);
      chk("acc.seq", 32'(bus.seq_state), 1);
      chk("acc.cmd", 32'(bus.cmd), 32'h01);
      cycles(TA - 1);
      chk("ta.early", 32'(bus.cur_operation), 0);
      cycles(1);
      chk("ta.cur", 32'(bus.cur_operation), 1);
      chk("ta.seq", 32'(bus.seq_state), 2);
      toggle();
      chk("ho1.cur", 32'(bus.cur_operation), 0);
      chk("ho1.resp", 32'(bus.resp_count), 1);
      cycles(GD - 1);
      chk("gd.seq", 32'(bus.seq_state), 3);
      cycles(1);
      chk("gd.idle", 32'(bus.seq_state), 0);

      pulse_cmd(8'hFF);
      cycles(TA);
      chk("tx2.seq", 32'(bus.seq_state), 2);
      toggle();
      chk("ho2.resp", 32'(bus.resp_count), 2);
      cycles(GD);

      pulse_cmd(8'h02);
      chk("uns.pulse", 32'(bus.err_unsupported), 1);
      chk("uns.seq", 32'(bus.seq_state), 0);
      chk("uns.cmd", 32'(bus.cmd), 32'hFF);
      cycles(1);
      chk("uns.end", 32'(bus.err_unsupported), 0);

      pulse_cmd(8'h00);
      cycles(3);
      pulse_cmd(8'hFF);
      chk("ovr.pulse", 32'(bus.err_overrun), 1);
      chk("ovr.cmd", 32'(bus.cmd), 32'h00);
      cycles(1);
      chk("ovr.end", 32'(bus.err_overrun), 0);
      cycles(TA - 5);
      chk("ovr.tx", 32'(bus.cur_operation), 1);
      toggle();
      cycles(GD);

      toggle();
      cycles(2);
      chk("idle.ho", 32'(bus.resp_count), 3);

`ifdef FAKE_N64_SEQ_TIMEOUT_EN
      pulse_cmd(8'h01);
      cycles(TA + TO - 1);
      chk("to.early", 32'(bus.err_timeout), 0);
      cycles(1);
      chk("to.pulse", 32'(bus.err_timeout), 1);
      chk("to.cur", 32'(bus.cur_operation), 0);
      chk("to.resp", 32'(bus.resp_count), 3);
      cycles(GD);
      pulse_cmd(8'h01);
      cycles(TA + TO - 1);
      toggle();
      chk("to.race", 32'(bus.resp_count), 4);
      chk("to.none", 32'(bus.err_timeout), 0);
      cycles(GD);
`endif

      for (int i = 0; i < 3000; i++) begin
         bus.rx_cmd_valid = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 3))
            0: bus.rx_cmd = 8'h00;
            1: bus.rx_cmd = 8'h01;
            2: bus.rx_cmd = 8'hFF;
            default: bus.rx_cmd = 8'($urandom);
         endcase
         if ($urandom_range(0, 24) == 0) bus.tx_handoff = ~bus.tx_handoff;
         @(negedge sample_clk);
      end
      bus.rx_cmd_valid = 1'b0;
      cycles(20);
      toggle();
      cycles(10);

      n = (m_resp == 8'd0) ? 256 : 256 - int'(m_resp);
      for (int i = 0; i < n; i++) begin
         pulse_cmd(8'h01);
         cycles(TA);
         toggle();
         cycles(GD);
      end
      chk("wrap.resp", 32'(bus.resp_count), 0);

      pulse_cmd(8'h01);
      cycles(TA + 4);
      #2 reset_n = 1'b0;
      #1;
      chk("ar.cur", 32'(bus.cur_operation), 0);
      chk("ar.seq", 32'(bus.seq_state), 0);
      chk("ar.cmd", 32'(bus.cmd), 0);
      chk("ar.resp", 32'(bus.resp_count), 0);
      chk("ar.err", 32'({bus.err_unsupported, bus.err_overrun,
                         bus.err_timeout}), 0);
      cycles(2);
      #2 reset_n = 1'b1;
      cycles(1);
      toggle();
      cycles(2);
      chk("ar.ho", 32'(bus.resp_count), 0);
      chk("ar.idle", 32'(bus.seq_state), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
